// File: rtl/core_defs.sv
// Shared core definitions: datapath width, reset vector, IFU state encoding
// and the memory response code used by the fetch, next-PC and LSU blocks.
package core_defs;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] IFU_S_AR_ENC   = 2'd0;
    localparam logic [1:0] IFU_S_R_ENC    = 2'd1;
    localparam logic [1:0] IFU_S_HOLD_ENC = 2'd2;
    localparam logic [1:0] IFU_S_ERR_ENC  = 2'd3;

    typedef enum logic [1:0] {
        S_AR   = IFU_S_AR_ENC,
        S_R    = IFU_S_R_ENC,
        S_HOLD = IFU_S_HOLD_ENC,
        S_ERR  = IFU_S_ERR_ENC
    } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per step over an
// AR/R read channel and holds it for decode until the downstream retires it.
module ifu
    import core_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_next,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  inst,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic             imem_arvalid,
    output logic [XLEN-1:0]  imem_araddr,
    input  logic             imem_arready,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic [1:0]       imem_rresp,
    output logic             imem_rready,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    ifu_state_e state;

    assign imem_araddr = pc;

    // Handshake outputs are registered alongside the next state so each one
    // changes exactly on the edge that enters or leaves its owning state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_AR;
            pc           <= RESET_PC;
            inst         <= '0;
            fetch_err    <= 1'b0;
            fetch_cnt    <= '0;
            imem_arvalid <= 1'b1;
            imem_rready  <= 1'b0;
            inst_valid   <= 1'b0;
        end else begin
            case (state)
                S_AR: begin
                    if (imem_arready) begin
                        state        <= S_R;
                        imem_arvalid <= 1'b0;
                        imem_rready  <= 1'b1;
                    end
                end
                S_R: begin
                    if (imem_rvalid) begin
                        imem_rready <= 1'b0;
                        if (imem_rresp == RESP_OKAY) begin
                            inst       <= imem_rdata;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                S_HOLD: begin
                    // A misaligned target still counts as retired; the error
                    // stops the next fetch rather than the current one.
                    if (inst_ready) begin
                        pc         <= pc_next;
                        fetch_cnt  <= fetch_cnt + CNT_W'(1);
                        inst_valid <= 1'b0;
                        if (pc_next[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            state     <= S_ERR;
                        end else begin
                            imem_arvalid <= 1'b1;
                            state        <= S_AR;
                        end
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state        <= S_ERR;
                    fetch_err    <= 1'b1;
                    imem_arvalid <= 1'b0;
                    imem_rready  <= 1'b0;
                    inst_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a scripted memory model drives AR/R and a
// queue of expected instructions is checked when the unit presents them.
module tb_ifu;
    import core_defs::*;

    localparam int               TB_CNT_W = 4;
    localparam logic [XLEN-1:0]  RST_PC   = 32'h8000_0000;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [XLEN-1:0]     pc_next = '0;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     inst;
    logic                inst_valid;
    logic                inst_ready = 1'b0;
    logic                imem_arvalid;
    logic [XLEN-1:0]     imem_araddr;
    logic                imem_arready = 1'b0;
    logic                imem_rvalid = 1'b0;
    logic [XLEN-1:0]     imem_rdata = '0;
    logic [1:0]          imem_rresp = 2'b00;
    logic                imem_rready;
    logic                fetch_err;
    logic [TB_CNT_W-1:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0]     exp_q[$];
    logic [XLEN-1:0]     exp_pc;
    logic [XLEN-1:0]     hold_inst;
    logic [TB_CNT_W-1:0] exp_cnt;

    ifu #(.RESET_PC(RST_PC), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .pc(pc), .inst(inst),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr),
        .imem_arready(imem_arready), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_rresp(imem_rresp),
        .imem_rready(imem_rready), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The memory only ever raises rvalid while it sees rready, so an R beat
    // outside the read phase means the unit dropped rready too early.
    always @(negedge clk) begin
        if (imem_rvalid && !imem_rready)
            checkOutput("rvalid_proto", 32'(imem_rready), 32'd1);
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_pc  = RST_PC;
        exp_cnt = '0;
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_arvalid", 32'(imem_arvalid), 32'd1);
        checkOutput("rst_araddr", imem_araddr, RST_PC);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_cnt", 32'(fetch_cnt), 32'd0);
        checkOutput("rst_err", 32'(fetch_err), 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
    endtask

    task automatic applyStimulus(input int ar_wait, input int r_wait,
                                 input logic [31:0] data, input logic [1:0] resp);
        checkOutput("ar_valid", 32'(imem_arvalid), 32'd1);
        checkOutput("ar_addr", imem_araddr, exp_pc);
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            checkOutput("ar_hold_valid", 32'(imem_arvalid), 32'd1);
            checkOutput("ar_hold_addr", imem_araddr, exp_pc);
        end
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        checkOutput("r_ready", 32'(imem_rready), 32'd1);
        checkOutput("ar_drop", 32'(imem_arvalid), 32'd0);
        checkOutput("r_no_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < r_wait; i++) begin
            tick();
            checkOutput("r_wait_valid", 32'(inst_valid), 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        imem_rresp  = resp;
        if (resp == RESP_OKAY) exp_q.push_back(data);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        imem_rresp  = 2'b00;
    endtask

    task automatic hold_check();
        checkOutput("hold_valid", 32'(inst_valid), 32'd1);
        checkOutput("hold_rready", 32'(imem_rready), 32'd0);
        if (exp_q.size() > 0) begin
            hold_inst = exp_q.pop_front();
            checkOutput("hold_inst", inst, hold_inst);
        end else begin
            checkOutput("sb_underflow", exp_q.size(), 32'd1);
        end
    endtask

    task automatic retire(input logic [31:0] nxt, input int stall);
        for (int i = 0; i < stall; i++) begin
            inst_ready = 1'b0;
            pc_next    = (i % 2 == 1) ? 32'h8000_0200 : 32'h8000_0300;
            tick();
            checkOutput("stall_pc", pc, exp_pc);
            checkOutput("stall_inst", inst, hold_inst);
            checkOutput("stall_valid", 32'(inst_valid), 32'd1);
        end
        inst_ready = 1'b1;
        pc_next    = nxt;
        tick();
        inst_ready = 1'b0;
        pc_next    = $urandom;
        exp_pc     = nxt;
        exp_cnt    = exp_cnt + 1'b1;
        checkOutput("ret_pc", pc, exp_pc);
        checkOutput("ret_cnt", 32'(fetch_cnt), 32'(exp_cnt));
        checkOutput("ret_valid", 32'(inst_valid), 32'd0);
        if (nxt[1:0] != 2'b00) begin
            checkOutput("misalign_err", 32'(fetch_err), 32'd1);
            checkOutput("misalign_noar", 32'(imem_arvalid), 32'd0);
        end else begin
            checkOutput("next_arvalid", 32'(imem_arvalid), 32'd1);
            checkOutput("next_araddr", imem_araddr, nxt);
            checkOutput("next_err", 32'(fetch_err), 32'd0);
        end
    endtask

    task automatic err_hold_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            checkOutput("err_sticky", 32'(fetch_err), 32'd1);
            checkOutput("err_noar", 32'(imem_arvalid), 32'd0);
            checkOutput("err_nor", 32'(imem_rready), 32'd0);
            checkOutput("err_novalid", 32'(inst_valid), 32'd0);
            checkOutput("err_pc", pc, exp_pc);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        do_reset();

        // Zero-wait fetch and a clean retire.
        applyStimulus(0, 0, 32'h0000_0413, RESP_OKAY);
        hold_check();
        retire(32'h8000_0004, 0);

        // Slow memory and a stalled downstream with pc_next wandering.
        applyStimulus(3, 4, 32'hDEAD_BEEF, RESP_OKAY);
        hold_check();
        retire(32'h8000_0100, 5);

        // Error response: sticky until reset.
        applyStimulus(0, 1, 32'h1234_5678, 2'b10);
        checkOutput("rresp_err", 32'(fetch_err), 32'd1);
        checkOutput("rresp_novalid", 32'(inst_valid), 32'd0);
        err_hold_check(3);
        do_reset();

        // Misaligned retire target.
        applyStimulus(1, 0, 32'h0010_0093, RESP_OKAY);
        hold_check();
        retire(32'h8000_0002, 1);
        err_hold_check(2);
        do_reset();

        // Reset while waiting for the R beat.
        applyStimulus(0, 0, 32'h0000_0013, RESP_OKAY);
        hold_check();
        retire(32'h8000_0008, 0);
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        checkOutput("in_r_ready", 32'(imem_rready), 32'd1);
        do_reset();

        // Reset while holding an instruction with a nonzero count.
        applyStimulus(0, 0, 32'h0000_0513, RESP_OKAY);
        hold_check();
        retire(32'h8000_0010, 0);
        applyStimulus(0, 0, 32'h0000_0613, RESP_OKAY);
        hold_check();
        do_reset();

        // Enough retires to wrap the narrow counter back to zero.
        for (int n = 0; n < (1 << TB_CNT_W); n++) begin
            applyStimulus($urandom_range(0, 2), $urandom_range(0, 2), $urandom, RESP_OKAY);
            hold_check();
            retire(exp_pc + 32'd4, $urandom_range(0, 1));
        end
        checkOutput("cnt_wrap", 32'(fetch_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
Instruction fetch unit. Owns the architectural PC register and fetches one 32-bit instruction per step from instruction memory over an AXI-lite-style read channel (AR/R). It holds the fetched instruction stable for decode/execute until the downstream stage accepts it, then loads the PC with pc_next produced by the next-PC generator. This makes the core a multi-cycle, handshake-driven design rather than a single-cycle one.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
CNT_W, 32, width of the retired-fetch counter.

Ports:
clk  input  1  core clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
pc_next  input  32  next PC from the next-PC generator; sampled only on the inst handshake.
pc  output  32  current PC; feeds the next-PC generator and decode.
inst  output  32  fetched instruction; valid while inst_valid=1.
inst_valid  output  1  instruction available to decode.
inst_ready  input  1  downstream has completed the instruction; inst_valid and inst_ready high together means retire.
imem_arvalid  output  1  read-address valid.
imem_araddr  output  32  read address; always equals pc.
imem_arready  input  1  memory accepts the address.
imem_rvalid  input  1  read data valid.
imem_rdata  input  32  read data.
imem_rresp  input  2  response code; 2'b00 = OKAY, any other value = fault.
imem_rready  output  1  unit accepts read data.
fetch_err  output  1  sticky fault flag.
fetch_cnt  output  CNT_W  number of retired instructions.

Behaviour:
- State machine states: S_AR, S_R, S_HOLD, S_ERR. The encoding is a localparam in the shared package.
- Reset (rst=1 at a clk edge), regardless of current state:
  - pc <= RESET_PC, state <= S_AR.
  - inst <= 32'h0, fetch_err <= 0, fetch_cnt <= 0.
  - Outputs take reset values the cycle after the reset edge. Memory is reset by the same rst, so no stale R beat is expected after reset.
- S_AR: imem_arvalid=1, imem_rready=0, inst_valid=0.
  - On imem_arready=1 -> S_R.
  - arvalid stays high and araddr stays stable until arready; never withdrawn.
- S_R: imem_arvalid=0, imem_rready=1.
  - On imem_rvalid=1 with rresp==00: inst <= imem_rdata, -> S_HOLD.
  - On imem_rvalid=1 with rresp!=00: fetch_err <= 1, -> S_ERR.
  - Zero-wait case: arready in cycle N and rvalid in cycle N+1 gives inst_valid in cycle N+2. Minimum fetch latency is 2 cycles from arvalid to inst_valid.
- S_HOLD: inst_valid=1, inst and pc held stable.
  - On inst_ready=1: pc <= pc_next, fetch_cnt <= fetch_cnt+1 (wraps modulo 2^CNT_W), -> S_AR.
  - If pc_next[1:0] != 2'b00 at retire: pc is still updated, fetch_err <= 1, -> S_ERR (misaligned target).
  - inst_ready while not in S_HOLD is ignored.
- S_ERR: all valids/readies low; pc and inst frozen.
  - Exits only via rst.
  - fetch_err stays high until rst.
- imem_araddr = pc combinationally in all states.
- Any imem_rvalid pulse outside S_R is ignored; it is a protocol violation and the bench flags it.
- A back-to-back retire is not possible: the minimum issue interval is 3 cycles (AR, R, HOLD).

Decomposition:
- Shared package (core_defs): XLEN=32, RESET_PC default, the IFU state encoding, and the RESP_OKAY=2'b00 constant. The next-PC generator and LSU reuse XLEN and RESP_OKAY.
- No sub-module; a single FSM plus registers. The retire counter stays inline.

Test Plan:
- Reset, then memory with arready=1 and rvalid one cycle later returning rdata=32'h00000413, inst_ready=1 -> araddr=0x80000000; inst_valid rises 2 cycles after arvalid; after retire with pc_next=0x80000004, pc=0x80000004 and fetch_cnt=1.
- Memory delays arready 3 cycles and rvalid 4 cycles -> arvalid and araddr held stable throughout; inst_valid only after the R beat; inst equals rdata.
- inst_ready held low for 5 cycles in S_HOLD with pc_next toggling between values -> pc and inst unchanged; pc takes only the pc_next value present on the ready cycle (e.g. 0x80000100).
- R beat with rresp=2'b10 -> fetch_err=1, state S_ERR, no arvalid afterwards; asserting rst clears it, and pc=0x80000000 with arvalid=1 the next cycle.
- Retire with pc_next=0x80000002 -> fetch_err=1, no new fetch issued.
- Assert rst while in S_R and in S_HOLD -> next cycle state S_AR, pc=RESET_PC, fetch_cnt=0, inst_valid=0. Separately, preload fetch_cnt=32'hFFFFFFFF and retire once -> fetch_cnt wraps to 0.
